// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and op classification helpers.
package mdu_pkg;

    typedef enum logic [3:0] {
        OpNop   = 4'd0,
        OpMult  = 4'd1,
        OpMultu = 4'd2,
        OpDiv   = 4'd3,
        OpDivu  = 4'd4,
        OpMthi  = 4'd5,
        OpMtlo  = 4'd6,
        OpMfhi  = 4'd7,
        OpMflo  = 4'd8,
        OpMadd  = 4'd9,
        OpMsub  = 4'd10
    } mdu_op_e;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } mdu_state_e;

    function automatic logic is_multicycle(logic [3:0] op);
        return op inside {OpMult, OpMultu, OpDiv, OpDivu, OpMadd, OpMsub};
    endfunction

    function automatic logic is_div(logic [3:0] op);
        return op inside {OpDiv, OpDivu};
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational HI/LO result for a multi-cycle op; hi/lo inputs feed the accumulate
// ops and are passed through whenever the op leaves HI/LO untouched.
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] phi,
    output logic [WIDTH-1:0] plo,
    output logic             div0
);

    localparam int unsigned W2 = 2 * WIDTH;

    logic signed [W2-1:0]    sprod;
    logic [W2-1:0]           uprod;
    logic [W2-1:0]           acc;
    logic                    ovf;
    logic [WIDTH-1:0]        b_udiv;
    logic [WIDTH-1:0]        b_sdiv;
    logic [WIDTH-1:0]        uq;
    logic [WIDTH-1:0]        ur;
    logic signed [WIDTH-1:0] sq;
    logic signed [WIDTH-1:0] sr;

    assign sprod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign acc   = {hi, lo};

    assign div0 = is_div(op) && (b == '0);
    assign ovf  = (a == {1'b1, {(WIDTH - 1){1'b0}}}) && (b == '1);

    // Divisors are forced to 1 in the cases overridden below so the divider never
    // sees a zero divisor or the INT_MIN / -1 overflow.
    assign b_udiv = (b == '0) ? WIDTH'(1) : b;
    assign b_sdiv = ((b == '0) || ovf) ? WIDTH'(1) : b;

    assign uq = a / b_udiv;
    assign ur = a % b_udiv;
    assign sq = $signed(a) / $signed(b_sdiv);
    assign sr = $signed(a) % $signed(b_sdiv);

    always_comb begin
        phi = hi;
        plo = lo;
        case (op)
            OpMult:  {phi, plo} = sprod;
            OpMultu: {phi, plo} = uprod;
            OpMadd:  {phi, plo} = acc + $unsigned(sprod);
            OpMsub:  {phi, plo} = acc - $unsigned(sprod);
            OpDivu: begin
                if (!div0) begin
                    plo = uq;
                    phi = ur;
                end
            end
            OpDiv: begin
                if (!div0) begin
                    if (ovf) begin
                        plo = a;
                        phi = '0;
                    end else begin
                        plo = sq;
                        phi = sr;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_iter_unit.sv
// Multiply/divide unit owning HI/LO: multi-cycle ops hold busy for a fixed cycle
// count and commit on the last edge; flush aborts without touching HI/LO.
module mdu_iter_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] out
);

    localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    mdu_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] phi, plo;
    logic             div0;

    // Fed from the latched operands; HI/LO cannot change while RUN, so the
    // accumulate ops still see the values present at start.
    mdu_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .hi   (hi_q),
        .lo   (lo_q),
        .phi  (phi),
        .plo  (plo),
        .div0 (div0)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (is_multicycle(op)) begin
                            op_d    = op;
                            a_d     = a;
                            b_d     = b;
                            cnt_d   = is_div(op) ? CntW'(DIV_CYCLES) : CntW'(MUL_CYCLES);
                            state_d = StRun;
                        end else if (op == OpMthi) begin
                            hi_d = a;
                        end else if (op == OpMtlo) begin
                            lo_d = a;
                        end
                    end
                end
                StRun: begin
                    if (cnt_q == CntW'(1)) begin
                        if (!div0) begin
                            hi_d = phi;
                            lo_d = plo;
                        end
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        out = '0;
        if (op == OpMfhi) begin
            out = hi_q;
        end else if (op == OpMflo) begin
            out = lo_q;
        end
    end

    assign busy = (state_q == StRun);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter_unit.sv
// Directed bench for mdu_iter_unit: busy-cycle counts, arithmetic results, moves,
// flush/reset aborts and start-while-busy, checked with immediate assertions.
module tb_mdu_iter_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] out;

    int tests = 0;
    int fails = 0;
    int n;

    mdu_iter_unit #(
        .WIDTH      (32),
        .MUL_CYCLES (5),
        .DIV_CYCLES (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo),
        .out   (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start strobe; returns one step past the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        op    = OpNop;
        a     = '0;
        b     = '0;
    endtask

    // Counts consecutive busy cycles starting from the current one (bounded).
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = OpNop;
        a     = '0;
        b     = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        // MULT -3 * 7 = -21
        issue(OpMult, 32'hFFFF_FFFD, 32'd7);
        count_busy(n);
        check("mult_cycles", n, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);

        issue(OpDivu, 32'd100, 32'd7);
        count_busy(n);
        check("divu_cycles", n, 32'd10);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        issue(OpDiv, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        check("div_cycles", n, 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // Back-to-back moves, then accumulate 2*3 onto {5, 9}
        start = 1'b1;
        op    = OpMthi;
        a     = 32'd5;
        tick();
        check("mthi_busy", {31'd0, busy}, 32'd0);
        op = OpMtlo;
        a  = 32'd9;
        tick();
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        op    = OpNop;
        check("mthi_hi", hi, 32'd5);
        check("mtlo_lo", lo, 32'd9);
        issue(OpMadd, 32'd2, 32'd3);
        count_busy(n);
        check("madd_cycles", n, 32'd5);
        check("madd_hi", hi, 32'd5);
        check("madd_lo", lo, 32'd15);
        op = OpMflo;
        #1;
        check("mflo_out", out, 32'd15);
        op = OpMfhi;
        #1;
        check("mfhi_out", out, 32'd5);
        op = OpNop;
        #1;
        check("nop_out", out, 32'd0);

        // MSUB 2*3 from {5, 15}
        issue(OpMsub, 32'd2, 32'd3);
        count_busy(n);
        check("msub_cycles", n, 32'd5);
        check("msub_hi", hi, 32'd5);
        check("msub_lo", lo, 32'd9);

        // Divide by zero leaves HI/LO alone
        issue(OpMthi, 32'h0000_00AA, 32'd0);
        issue(OpMtlo, 32'h0000_00BB, 32'd0);
        issue(OpDiv, 32'd7, 32'd0);
        count_busy(n);
        check("div0_cycles", n, 32'd10);
        check("div0_hi", hi, 32'h0000_00AA);
        check("div0_lo", lo, 32'h0000_00BB);

        issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n);
        check("ovf_cycles", n, 32'd10);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);

        // Flush on the 3rd busy cycle
        issue(OpMult, 32'd4, 32'd5);
        tick();
        tick();
        check("flush3_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush3_busy", {31'd0, busy}, 32'd0);
        repeat (6) tick();
        check("flush3_hi", hi, 32'd0);
        check("flush3_lo", lo, 32'h8000_0000);

        // Flush on the commit edge (5th busy cycle)
        issue(OpMult, 32'd4, 32'd5);
        repeat (4) tick();
        check("flushc_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flushc_busy", {31'd0, busy}, 32'd0);
        check("flushc_hi", hi, 32'd0);
        check("flushc_lo", lo, 32'h8000_0000);

        // start together with flush while idle is dropped
        start = 1'b1;
        flush = 1'b1;
        op    = OpMultu;
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        flush = 1'b0;
        op    = OpNop;
        check("stflush_busy", {31'd0, busy}, 32'd0);
        tick();
        check("stflush_hi", hi, 32'd0);
        check("stflush_lo", lo, 32'h8000_0000);

        // MULTU started mid-run must not disturb the MULT in flight
        issue(OpMult, 32'd4, 32'd5);
        tick();
        start = 1'b1;
        op    = OpMultu;
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        op    = OpNop;
        count_busy(n);
        check("stbusy_cycles", n + 2, 32'd5);
        check("stbusy_hi", hi, 32'd0);
        check("stbusy_lo", lo, 32'd20);
        tick();
        check("stbusy_idle", {31'd0, busy}, 32'd0);

        // Reset mid-run
        issue(OpMthi, 32'h0000_0011, 32'd0);
        issue(OpMult, 32'd6, 32'd7);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        repeat (6) tick();
        check("rst_lo_late", lo, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
